// File: rtl/riscv_control_fsm_if.sv
// riscv_control_fsm_if: instruction fields and status in, datapath controls out.
interface riscv_control_fsm_if #(parameter int ALU_CTRL_W = 3);
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5;
  logic Z;
  logic mem_ready;
  logic PCWrite;
  logic AdrSrc;
  logic MemWrite;
  logic IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic RegWrite;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic instr_done;
  logic illegal_instr;
  modport master (
    input op, funct3, funct7b5, Z, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
           RegWrite, ALUControl, instr_done, illegal_instr
  );
  modport slave (
    output op, funct3, funct7b5, Z, mem_ready,
    input PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
          RegWrite, ALUControl, instr_done, illegal_instr
  );
endinterface

// File: rtl/riscv_control_fsm.sv
// riscv_control_fsm: multi-cycle RV32I subset main controller driving the datapath and ALU.
module riscv_control_fsm #(parameter int ALU_CTRL_W = 3) (
  input logic clk,
  input logic rst_n,
  riscv_control_fsm_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB, EXECR, EXECI, ALUWB, BEQ, JAL
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  state_t state, next;
  logic pc_write, ir_write, adr_src, mem_write, reg_write, done, illegal;
  logic [1:0] result_src, src_a, src_b, imm_src;
  logic [ALU_CTRL_W-1:0] alu_ctrl, funct_alu;
  assign funct_alu = bus.funct3 == 3'b000 ? ((bus.op == OP_R && bus.funct7b5) ? 3'b001 : 3'b000) :
                     bus.funct3 == 3'b010 ? 3'b101 :
                     bus.funct3 == 3'b100 ? 3'b011 :
                     bus.funct3 == 3'b110 ? 3'b110 :
                     bus.funct3 == 3'b111 ? 3'b010 : 3'b000;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= next;
  always_comb begin
    next = state;
    pc_write = 1'b0;
    ir_write = 1'b0;
    adr_src = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    done = 1'b0;
    illegal = 1'b0;
    result_src = 2'b00;
    src_a = 2'b00;
    src_b = 2'b00;
    imm_src = 2'b00;
    alu_ctrl = '0;
    case (state)
      FETCH: begin
        src_b = 2'b10;
        result_src = 2'b10;
        ir_write = bus.mem_ready;
        pc_write = bus.mem_ready;
        next = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        imm_src = 2'b10;
        case (bus.op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R: next = EXECR;
          OP_I: next = EXECI;
          OP_BEQ: next = BEQ;
          OP_JAL: next = JAL;
          default: begin
            illegal = 1'b1;
            next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
        imm_src = bus.op == OP_SW ? 2'b01 : 2'b00;
        next = bus.op == OP_SW ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        next = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_write = 1'b1;
        done = bus.mem_ready;
        next = bus.mem_ready ? FETCH : MEMWRITE;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write = 1'b1;
        done = 1'b1;
        next = FETCH;
      end
      EXECR: begin
        src_a = 2'b10;
        alu_ctrl = funct_alu;
        next = ALUWB;
      end
      EXECI: begin
        src_a = 2'b10;
        src_b = 2'b01;
        alu_ctrl = funct_alu;
        next = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        done = 1'b1;
        next = FETCH;
      end
      BEQ: begin
        src_a = 2'b10;
        alu_ctrl = 3'b001;
        pc_write = bus.Z;
        done = 1'b1;
        next = FETCH;
      end
      JAL: begin
        src_a = 2'b01;
        src_b = 2'b10;
        imm_src = 2'b11;
        pc_write = 1'b1;
        next = ALUWB;
      end
      default: next = FETCH;
    endcase
  end
  // Register enables must not fire while reset is held, even though FETCH decode is visible.
  assign bus.PCWrite = pc_write & rst_n;
  assign bus.IRWrite = ir_write & rst_n;
  assign bus.AdrSrc = adr_src;
  assign bus.MemWrite = mem_write;
  assign bus.RegWrite = reg_write;
  assign bus.instr_done = done;
  assign bus.illegal_instr = illegal;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA = src_a;
  assign bus.ALUSrcB = src_b;
  assign bus.ImmSrc = imm_src;
  assign bus.ALUControl = alu_ctrl;
endmodule

// File: tb/tb_riscv_control_fsm.sv
// tb_riscv_control_fsm: random and directed instruction streams checked against a step-sequence model.
module tb_riscv_control_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  riscv_control_fsm_if bus ();
  riscv_control_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef enum {S_F, S_D, S_DILL, S_MALW, S_MASW, S_MR, S_MW, S_MWB, S_ER, S_EI, S_AWB, S_BEQ, S_JAL} step_t;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  function automatic logic [17:0] pk(input logic pcw, adr, mw, irw, input logic [1:0] rs, asa, asb, imm,
                                     input logic rw, input logic [2:0] alu, input logic dn, ill);
    return {pcw, adr, mw, irw, rs, asa, asb, imm, rw, alu, dn, ill};
  endfunction
  function automatic logic [17:0] actual();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
            bus.ImmSrc, bus.RegWrite, bus.ALUControl, bus.instr_done, bus.illegal_instr};
  endfunction
  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000: return (o == RT && f7) ? 3'b001 : 3'b000;
      3'b010: return 3'b101;
      3'b100: return 3'b011;
      3'b110: return 3'b110;
      3'b111: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction
  function automatic logic [17:0] expect_of(input step_t s, input logic mr, z, input logic [2:0] alu);
    case (s)
      S_F:    return pk(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000, 0, 0);
      S_D:    return pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 0, 3'b000, 0, 0);
      S_DILL: return pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 0, 3'b000, 0, 1);
      S_MALW: return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000, 0, 0);
      S_MASW: return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 0, 3'b000, 0, 0);
      S_MR:   return pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0, 0);
      S_MW:   return pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, mr, 0);
      S_MWB:  return pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 3'b000, 1, 0);
      S_ER:   return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, alu, 0, 0);
      S_EI:   return pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, alu, 0, 0);
      S_AWB:  return pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000, 1, 0);
      S_BEQ:  return pk(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b001, 1, 0);
      default: return pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 0, 3'b000, 0, 0);
    endcase
  endfunction
  // mode 0: mem_ready high except `stalls` low cycles in the data access; mode 1: random. zmode 2: random Z.
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int mode, input int zmode, input int stalls, output int done_cyc);
    step_t steps[$];
    int idx = 0, cyc = 0, left = stalls;
    logic mr, z;
    logic [2:0] alu = alu_of(o, f3, f7);
    case (o)
      LW: steps = '{S_F, S_D, S_MALW, S_MR, S_MWB};
      SW: steps = '{S_F, S_D, S_MASW, S_MW};
      RT: steps = '{S_F, S_D, S_ER, S_AWB};
      IT: steps = '{S_F, S_D, S_EI, S_AWB};
      BQ: steps = '{S_F, S_D, S_BEQ};
      JL: steps = '{S_F, S_D, S_JAL, S_AWB};
      default: steps = '{S_F, S_DILL};
    endcase
    done_cyc = 0;
    while (idx < steps.size() && cyc < 60) begin
      @(negedge clk);
      mr = 1'b1;
      if (mode == 1) mr = $urandom_range(0, 3) != 0;
      else if ((steps[idx] == S_MR || steps[idx] == S_MW) && left > 0) begin
        mr = 1'b0;
        left--;
      end
      z = zmode == 2 ? 1'($urandom_range(0, 1)) : 1'(zmode);
      bus.op = o;
      bus.funct3 = f3;
      bus.funct7b5 = f7;
      bus.mem_ready = mr;
      bus.Z = z;
      #1;
      checks++;
      if (actual() !== expect_of(steps[idx], mr, z, alu)) begin
        errors++;
        $display("FAIL %s op=%b cyc=%0d step=%s got=%b exp=%b", tag, o, cyc, steps[idx].name(), actual(),
                 expect_of(steps[idx], mr, z, alu));
      end
      cyc++;
      if (bus.instr_done === 1'b1 && done_cyc == 0) done_cyc = cyc;
      if (!((steps[idx] == S_F || steps[idx] == S_MR || steps[idx] == S_MW) && !mr)) idx++;
    end
    if (idx < steps.size()) begin
      errors++;
      checks++;
      $display("FAIL %s timeout idx=%0d required=%0d", tag, idx, steps.size());
    end
  endtask
  task automatic check_latency(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s latency got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic test_reset();
    bus.op = RT;
    bus.funct3 = 3'b000;
    bus.funct7b5 = 1'b1;
    bus.Z = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (actual() !== pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000, 0, 0)) begin
        errors++;
        $display("FAIL reset_outputs got=%b", actual());
      end
    end
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic test_rtype_sub();
    int d;
    run_instr("sub", RT, 3'b000, 1'b1, 0, 0, 0, d);
    check_latency("sub", d, 4);
  endtask
  task automatic test_lw_stall();
    int d;
    run_instr("lw_stall", LW, 3'b010, 1'b0, 0, 0, 2, d);
    check_latency("lw_stall", d, 7);
    run_instr("lw", LW, 3'b010, 1'b0, 0, 0, 0, d);
    check_latency("lw", d, 5);
    run_instr("sw", SW, 3'b010, 1'b0, 0, 0, 0, d);
    check_latency("sw", d, 4);
  endtask
  task automatic test_beq();
    int d;
    run_instr("beq_z1", BQ, 3'b000, 1'b0, 0, 1, 0, d);
    check_latency("beq_z1", d, 3);
    run_instr("beq_z0", BQ, 3'b000, 1'b0, 0, 0, 0, d);
    check_latency("beq_z0", d, 3);
  endtask
  task automatic test_itype();
    int d;
    logic [2:0] f3s[5] = '{3'b010, 3'b110, 3'b111, 3'b100, 3'b000};
    foreach (f3s[i]) begin
      run_instr("itype", IT, f3s[i], 1'b1, 0, 0, 0, d);
      check_latency("itype", d, 4);
    end
    run_instr("jal", JL, 3'b000, 1'b0, 0, 0, 0, d);
    check_latency("jal", d, 4);
  endtask
  task automatic test_illegal();
    int d;
    run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 0, 0, 0, d);
    check_latency("illegal_no_done", d, 0);
  endtask
  task automatic test_reset_mid_sw();
    int d;
    run_instr("sw_pre", SW, 3'b010, 1'b0, 0, 0, 0, d);
    bus.op = SW;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (actual() !== pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0, 0)) begin
      errors++;
      $display("FAIL sw_stall_memwrite got=%b", actual());
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.MemWrite !== 1'b0 || bus.instr_done !== 1'b0) begin
      errors++;
      $display("FAIL sw_async_reset MemWrite=%b instr_done=%b exp 0 0", bus.MemWrite, bus.instr_done);
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (actual() !== pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000, 0, 0)) begin
      errors++;
      $display("FAIL reset_gating got=%b", actual());
    end
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    run_instr("after_reset", RT, 3'b111, 1'b0, 0, 0, 0, d);
    check_latency("after_reset", d, 4);
  endtask
  task automatic test_random();
    int d;
    logic [6:0] ops[6] = '{LW, SW, RT, IT, BQ, JL};
    logic [6:0] o;
    for (int n = 0; n < 80; n++) begin
      int k = $urandom_range(0, 6);
      o = k == 6 ? 7'($urandom) : ops[k];
      run_instr("random", o, 3'($urandom), 1'($urandom), 1, 2, 0, d);
    end
  endtask
  initial begin
    bus.op = '0;
    bus.funct3 = '0;
    bus.funct7b5 = 1'b0;
    bus.Z = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_rtype_sub();
    test_lw_stall();
    test_beq();
    test_itype();
    test_illegal();
    test_reset_mid_sw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
